orv64_dbg_halt_ctrl: RTL

ORV64_DBG_HALT_CTRL -- requirements
Module: orv64_dbg_halt_ctrl

---
 rtl/orv64_typedef_pkg.sv | 21 ++
 rtl/orv64_dbg_halt_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/orv64_typedef_pkg.sv
// Shared debug-halt types for the orv64 core: halt cause encoding and the
// halt-controller state encoding.
package orv64_typedef_pkg;

   typedef enum logic [1:0] {
      HALT_CAUSE_NONE = 2'd0,
      HALT_CAUSE_BP   = 2'd1,
      HALT_CAUSE_REQ  = 2'd2,
      HALT_CAUSE_STEP = 2'd3
   } orv64_halt_cause_e;

   typedef enum logic [1:0] {
      DBG_RUN      = 2'd0,
      DBG_HALTING  = 2'd1,
      DBG_HALTED   = 2'd2,
      DBG_STEPPING = 2'd3
   } orv64_dbg_state_e;

   localparam logic [15:0] HALT_CNT_MAX = 16'hFFFF;

endpackage : orv64_typedef_pkg

// File: rtl/orv64_dbg_halt_ctrl.sv
// Debug halt/resume/single-step controller for the orv64 core.
// Optional instruction stepping is built only when ORV64_DBG_STEP_EN is defined.
module orv64_dbg_halt_ctrl
   import orv64_typedef_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bp_stall,
   input  logic        halt_req,
   input  logic        resume_req,
   input  logic        step_req,
   input  logic [7:0]  step_num,
   input  logic        wb_valid,
   input  logic        core_idle,
   output logic        core_halt,
   output logic        halted,
   output logic        resume_ack,
   output logic [1:0]  halt_cause,
   output logic [15:0] halt_cnt
);

   orv64_dbg_state_e  state_reg, state_next;
   orv64_halt_cause_e cause_reg, cause_next;
   logic              bp_mask_reg, bp_mask_next;
   logic              ack_reg, ack_next;
   logic              core_halt_reg, halted_reg;
   logic [15:0]       halt_cnt_reg;
   logic              cnt_inc;
   logic              bp_hit;

`ifdef ORV64_DBG_STEP_EN
   logic [7:0]        step_cnt_reg, step_cnt_next;
`else
   logic              unused_step;
   assign unused_step = ^{step_req, step_num};
`endif

   // The mask hides the breakpoint we resumed from until one instruction retires.
   assign bp_hit = bp_stall & ~bp_mask_reg;

   always_comb begin
      state_next   = state_reg;
      cause_next   = cause_reg;
      bp_mask_next = bp_mask_reg;
      ack_next     = 1'b0;
      cnt_inc      = 1'b0;
`ifdef ORV64_DBG_STEP_EN
      step_cnt_next = step_cnt_reg;
`endif
      if (wb_valid && (state_reg == DBG_RUN || state_reg == DBG_STEPPING))
         bp_mask_next = 1'b0;

      case (state_reg)
         DBG_RUN: begin
            if (bp_hit) begin
               state_next = DBG_HALTING;
               cause_next = HALT_CAUSE_BP;
            end else if (halt_req) begin
               state_next = DBG_HALTING;
               cause_next = HALT_CAUSE_REQ;
            end
         end
         DBG_HALTING: begin
            if (core_idle) begin
               state_next = DBG_HALTED;
               cnt_inc    = 1'b1;
            end
         end
         DBG_HALTED: begin
`ifdef ORV64_DBG_STEP_EN
            if (step_req) begin
               state_next    = DBG_STEPPING;
               ack_next      = 1'b1;
               bp_mask_next  = 1'b1;
               step_cnt_next = (step_num == 8'd0) ? 8'd1 : step_num;
            end else
`endif
            if (resume_req) begin
               state_next   = DBG_RUN;
               ack_next     = 1'b1;
               bp_mask_next = 1'b1;
            end
         end
`ifdef ORV64_DBG_STEP_EN
         DBG_STEPPING: begin
            if (bp_hit) begin
               state_next = DBG_HALTING;
               cause_next = HALT_CAUSE_BP;
            end else if (halt_req) begin
               state_next = DBG_HALTING;
               cause_next = HALT_CAUSE_REQ;
            end else if (wb_valid) begin
               if (step_cnt_reg == 8'd1) begin
                  state_next = DBG_HALTING;
                  cause_next = HALT_CAUSE_STEP;
               end
               step_cnt_next = step_cnt_reg - 8'd1;
            end
         end
`endif
         default: state_next = DBG_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= DBG_RUN;
         cause_reg     <= HALT_CAUSE_NONE;
         bp_mask_reg   <= 1'b0;
         ack_reg       <= 1'b0;
         core_halt_reg <= 1'b0;
         halted_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cause_reg     <= cause_next;
         bp_mask_reg   <= bp_mask_next;
         ack_reg       <= ack_next;
         core_halt_reg <= (state_next == DBG_HALTING) || (state_next == DBG_HALTED);
         halted_reg    <= (state_next == DBG_HALTED);
      end
   end

   // Counter only writes on a halt, holding its value otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         halt_cnt_reg <= 16'd0;
      else if (cnt_inc && halt_cnt_reg != HALT_CNT_MAX)
         halt_cnt_reg <= halt_cnt_reg + 16'd1;
   end

`ifdef ORV64_DBG_STEP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         step_cnt_reg <= 8'd0;
      else
         step_cnt_reg <= step_cnt_next;
   end
`endif

   assign core_halt  = core_halt_reg;
   assign halted     = halted_reg;
   assign resume_ack = ack_reg;
   assign halt_cause = cause_reg;
   assign halt_cnt   = halt_cnt_reg;

endmodule : orv64_dbg_halt_ctrl
